// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch PC generator.
//   fetch_state_e - sequencer states (BOOT, RUN, REDIRECT)
//   INSTR_BYTES   - sequential fetch stride in bytes
//   CTR_W         - width of the performance counters
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int CTR_W       = 32;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: saturating event counter.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset, clears the count
//   inc_i   - count one event this cycle
//   count_o - registered count, holds at all-ones once reached
module fetch_perf_ctr
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CTR_W-1:0] count_o
);

  logic [CTR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction fetch address sequencer with branch redirect.
// Optional feature macro: FETCH_PERF_EN (performance counters; tied to 0 when
// undefined).
// Ports:
//   clk              - clock, rising edge
//   reset            - synchronous active-high reset
//   inBrValid        - one-cycle branch redirect request
//   inBta            - branch target address (bits [1:0] are dropped)
//   inFetchReady     - instruction memory accepts outFetchPc this cycle
//   outFetchValid    - fetch request valid
//   outFetchPc       - fetch address
//   outFlush         - one-cycle pulse after every accepted redirect
//   outMisalign      - pulses with outFlush when the target was misaligned
//   outFetchCount    - completed fetch handshakes (saturating)
//   outRedirectCount - accepted redirects (saturating)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | first cycle after reset, no fetch request, PC = RESET_PC
// RUN      | fetching sequentially, redirects taken on handshake
// REDIRECT | redirect arrived during a stall; held PC still requested,
//          | pending target applied when the handshake completes
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inBrValid,
  input  logic [BUS_DATA_WIDTH-1:0] inBta,
  input  logic                      inFetchReady,
  output logic                      outFetchValid,
  output logic [BUS_DATA_WIDTH-1:0] outFetchPc,
  output logic                      outFlush,
  output logic                      outMisalign,
  output logic [CTR_W-1:0]          outFetchCount,
  output logic [CTR_W-1:0]          outRedirectCount
);

  fetch_state_e              state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_DATA_WIDTH-1:0] pend_q, pend_d;
  logic                      valid_q, valid_d;
  logic                      flush_q, flush_d;
  logic                      misalign_q, misalign_d;

  logic                      hs;
  logic [BUS_DATA_WIDTH-1:0] bta_al;
  logic [BUS_DATA_WIDTH-1:0] pc_inc;

  assign hs     = valid_q & inFetchReady;
  assign bta_al = {inBta[BUS_DATA_WIDTH-1:2], 2'b00};
  // Plain add wraps naturally at 2^BUS_DATA_WIDTH.
  assign pc_inc = pc_q + BUS_DATA_WIDTH'(INSTR_BYTES);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;

    // Every redirect is accepted in every state; only where the target lands
    // depends on the state and the handshake.
    if (inBrValid) begin
      flush_d    = 1'b1;
      misalign_d = |inBta[1:0];
    end

    case (state_q)
      ST_BOOT: begin
        valid_d = 1'b1;
        state_d = ST_RUN;
        if (inBrValid) begin
          pc_d = bta_al;
        end
      end
      ST_RUN: begin
        valid_d = 1'b1;
        if (inBrValid) begin
          if (hs) begin
            pc_d = bta_al;
          end else begin
            // Stalled: keep the requested PC stable, remember the target.
            pend_d  = bta_al;
            state_d = ST_REDIRECT;
          end
        end else if (hs) begin
          pc_d = pc_inc;
        end
      end
      ST_REDIRECT: begin
        valid_d = 1'b1;
        if (inBrValid) begin
          pend_d = bta_al;
        end
        if (hs) begin
          // A redirect arriving on the releasing cycle is the newest target.
          pc_d    = inBrValid ? bta_al : pend_q;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign outFetchValid = valid_q;
  assign outFetchPc    = pc_q;
  assign outFlush      = flush_q;
  assign outMisalign   = misalign_q;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_fetch_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (hs),
    .count_o (outFetchCount)
  );

  fetch_perf_ctr u_redirect_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (inBrValid),
    .count_o (outRedirectCount)
  );
`else
  assign outFetchCount    = '0;
  assign outRedirectCount = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vector bench for fetch_pc_gen (default parameters).
module tb_fetch_pc_gen;

  logic        clk;
  logic        reset;
  logic        inBrValid;
  logic [63:0] inBta;
  logic        inFetchReady;
  logic        outFetchValid;
  logic [63:0] outFetchPc;
  logic        outFlush;
  logic        outMisalign;
  logic [31:0] outFetchCount;
  logic [31:0] outRedirectCount;

  int n_chk = 0;
  int n_err = 0;

  fetch_pc_gen dut (
    .clk              (clk),
    .reset            (reset),
    .inBrValid        (inBrValid),
    .inBta            (inBta),
    .inFetchReady     (inFetchReady),
    .outFetchValid    (outFetchValid),
    .outFetchPc       (outFetchPc),
    .outFlush         (outFlush),
    .outMisalign      (outMisalign),
    .outFetchCount    (outFetchCount),
    .outRedirectCount (outRedirectCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record: inputs driven before an edge, outputs expected after it.
  typedef struct {
    logic        rst;
    logic        br;
    logic [63:0] bta;
    logic        rdy;
    logic        ev;
    logic [63:0] epc;
    logic        ef;
    logic        em;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic br, input logic [63:0] bta,
                     input logic rdy, input logic ev, input logic [63:0] epc,
                     input logic ef, input logic em);
    vec_t v;
    v.rst = rst; v.br = br; v.bta = bta; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ef = ef; v.em = em;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic br, input logic [63:0] bta,
                      input logic rdy);
    reset = rst; inBrValid = br; inBta = bta; inFetchReady = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_fc;
  logic [31:0] exp_rc;

  initial begin
    reset = 1'b1; inBrValid = 1'b0; inBta = '0; inFetchReady = 1'b0;
    #2;

    //  rst br  bta                    rdy  valid pc                     flush mis
    add(1, 0, 64'h0,                   1,   0, 64'h0,                    0, 0);
    add(1, 0, 64'h0,                   1,   0, 64'h0,                    0, 0);
    // Release: BOOT then 0x0, 0x4, 0x8
    add(0, 0, 64'h0,                   1,   1, 64'h0,                    0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h4,                    0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h8,                    0, 0);
    // Redirect with handshake, latency 1
    add(0, 1, 64'h1000,                1,   1, 64'h1000,                 1, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h1004,                 0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h1008,                 0, 0);
    add(0, 1, 64'h20,                  1,   1, 64'h20,                   1, 0);
    // Stall 3 cycles at 0x20, redirect to 0x400 in the first
    add(0, 1, 64'h400,                 0,   1, 64'h20,                   1, 0);
    add(0, 0, 64'h0,                   0,   1, 64'h20,                   0, 0);
    add(0, 0, 64'h0,                   0,   1, 64'h20,                   0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h400,                  0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h404,                  0, 0);
    // Two redirects while stalled, newest wins
    add(0, 1, 64'h400,                 0,   1, 64'h404,                  1, 0);
    add(0, 1, 64'h800,                 0,   1, 64'h404,                  1, 0);
    add(0, 0, 64'h0,                   0,   1, 64'h404,                  0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h800,                  0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h804,                  0, 0);
    // Misaligned targets
    add(0, 1, 64'h1002,                1,   1, 64'h1000,                 1, 1);
    add(0, 0, 64'h0,                   1,   1, 64'h1004,                 0, 0);
    add(0, 1, 64'h2003,                0,   1, 64'h1004,                 1, 1);
    add(0, 0, 64'h0,                   1,   1, 64'h2000,                 0, 0);
    // Reset while in REDIRECT discards the pending target
    add(0, 1, 64'h3000,                0,   1, 64'h2000,                 1, 0);
    add(1, 1, 64'h5000,                1,   0, 64'h0,                    0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h0,                    0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h4,                    0, 0);
    // Wrap at the top of the address space
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1,   1, 64'hFFFF_FFFF_FFFF_FFFC,  1, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h0,                    0, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h4,                    0, 0);
    // Redirect in BOOT (misaligned)
    add(1, 0, 64'h0,                   1,   0, 64'h0,                    0, 0);
    add(0, 1, 64'h77,                  1,   1, 64'h74,                   1, 1);
    add(0, 0, 64'h0,                   1,   1, 64'h78,                   0, 0);
    // Redirect in REDIRECT on the releasing handshake
    add(0, 1, 64'h100,                 0,   1, 64'h78,                   1, 0);
    add(0, 1, 64'h200,                 1,   1, 64'h200,                  1, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h204,                  0, 0);
    // Back-to-back redirects with handshakes
    add(0, 1, 64'h300,                 1,   1, 64'h300,                  1, 0);
    add(0, 1, 64'h310,                 1,   1, 64'h310,                  1, 0);
    add(0, 0, 64'h0,                   1,   1, 64'h314,                  0, 0);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].br, vt[i].bta, vt[i].rdy);
      chk($sformatf("v%0d valid", i), 64'(outFetchValid), 64'(vt[i].ev));
      chk($sformatf("v%0d pc", i),    outFetchPc,         vt[i].epc);
      chk($sformatf("v%0d flush", i), 64'(outFlush),      64'(vt[i].ef));
      chk($sformatf("v%0d misal", i), 64'(outMisalign),   64'(vt[i].em));
    end

    // Performance counters: 10 handshakes, 2 redirects
`ifdef FETCH_PERF_EN
    exp_fc = 32'd10;
    exp_rc = 32'd2;
`else
    exp_fc = 32'd0;
    exp_rc = 32'd0;
`endif
    step(1, 0, 64'h0, 1);
    chk("ctr fetch after reset",    64'(outFetchCount),    64'h0);
    chk("ctr redirect after reset", 64'(outRedirectCount), 64'h0);
    step(0, 0, 64'h0, 1);                  // BOOT: no request, no count
    for (int k = 0; k < 8; k++) step(0, 0, 64'h0, 1);
    step(0, 0, 64'h0, 0);                  // stall, not counted
    step(0, 1, 64'h600, 1);
    step(0, 1, 64'h700, 1);
    step(0, 0, 64'h0, 0);
    chk("ctr fetch count",    64'(outFetchCount),    64'(exp_fc));
    chk("ctr redirect count", 64'(outRedirectCount), 64'(exp_rc));
    chk("ctr seq pc",         outFetchPc,            64'h700);
    step(1, 0, 64'h0, 0);
    chk("ctr fetch cleared",    64'(outFetchCount),    64'h0);
    chk("ctr redirect cleared", 64'(outRedirectCount), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
